// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants, symbolic op codes and loader FSM states.
// The opcode/funct values match those decoded by the ControlUnit.
package mips_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_SLT  = 4'd4,
        OP_LW   = 4'd5,
        OP_SW   = 4'd6,
        OP_BEQ  = 4'd7,
        OP_ADDI = 4'd8
    } op_e;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [5:0] fn);
        return {OPC_RTYPE, rs, rt, rd, 5'b00000, fn};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] opc, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

endpackage

// File: rtl/mips_word_pack.sv
// Combinational packer: symbolic op plus fields -> 32-bit MIPS word and a legal flag.
module mips_word_pack
    import mips_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [15:0] imm_i,
    output logic [31:0] word_o,
    output logic        legal_o
);

    always_comb begin
        word_o  = 32'h0;
        legal_o = 1'b1;
        case (op_i)
            OP_ADD:  word_o = r_word(rs_i, rt_i, rd_i, FN_ADD);
            OP_SUB:  word_o = r_word(rs_i, rt_i, rd_i, FN_SUB);
            OP_AND:  word_o = r_word(rs_i, rt_i, rd_i, FN_AND);
            OP_OR:   word_o = r_word(rs_i, rt_i, rd_i, FN_OR);
            OP_SLT:  word_o = r_word(rs_i, rt_i, rd_i, FN_SLT);
            OP_LW:   word_o = i_word(OPC_LW, rs_i, rt_i, imm_i);
            OP_SW:   word_o = i_word(OPC_SW, rs_i, rt_i, imm_i);
            OP_BEQ:  word_o = i_word(OPC_BEQ, rs_i, rt_i, imm_i);
            OP_ADDI: word_o = i_word(OPC_ADDI, rs_i, rt_i, imm_i);
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_instr_encoder.sv
// Program loader: accepts symbolic instruction requests, encodes them and writes
// them sequentially into instruction memory starting at BASE_ADDR.
module mips_instr_encoder
    import mips_pkg::*;
#(
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              finish,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [15:0]       req_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              err_illegal,
    output state_e            dbg_state
);

    localparam int                DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);

    state_e              state_q;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic                err_q;
    logic [31:0]         word;
    logic                legal;
    logic                accept;

    mips_word_pack u_pack (
        .op_i    (req_op),
        .rs_i    (req_rs),
        .rt_i    (req_rt),
        .rd_i    (req_rd),
        .imm_i   (req_imm),
        .word_o  (word),
        .legal_o (legal)
    );

    // Handshake: a request transfers on any rising edge where req_valid && req_ready;
    // req_ready depends only on registered state, so the requester may hold valid freely.
    assign req_ready = (state_q == ST_LOAD) && (count_q < DEPTH_C);
    assign accept    = req_valid && req_ready;
    assign ptr_d     = ptr_q + 1'b1;
    assign count_d   = count_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= BASE;
            count_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= BASE;
            wdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q <= ST_LOAD;
                        ptr_q   <= BASE;
                        count_q <= '0;
                        addr_q  <= BASE;
                        err_q   <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    // Illegal ops complete the handshake but leave pointer and count alone.
                    if (accept) begin
                        if (legal) begin
                            we_q    <= 1'b1;
                            addr_q  <= ptr_q;
                            wdata_q <= word;
                            ptr_q   <= ptr_d;
                            count_q <= count_d;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    if (finish) state_q <= ST_DRAIN;
                end
                ST_DRAIN: state_q <= ST_DONE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    assign imem_we     = we_q;
    assign imem_addr   = addr_q;
    assign imem_wdata  = wdata_q;
    assign count       = count_q;
    assign busy        = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
    assign done        = (state_q == ST_DONE);
    assign err_illegal = err_q;
    assign dbg_state   = state_q;

endmodule
